// File: rtl/jk_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_meter_pkg
// Purpose  : Shared types and default widths for the JK toggle meter.
//            - jk_meter_state_t : measurement FSM states (IDLE/RUN/HOLD)
//            - JK_CNT_W         : default transition-counter width
//            - JK_WIN_W         : default window-length width
// Revision : 1.0 - initial release
// ============================================================================
package jk_meter_pkg;

  localparam int JK_CNT_W = 8;
  localparam int JK_WIN_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } jk_meter_state_t;

endpackage : jk_meter_pkg
`default_nettype wire

// File: rtl/jk_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : jk_edge_det
// Purpose  : Edge detector for the observed JK flop output. Keeps a one-cycle
//            delayed copy (q_d) that updates every cycle and flags 0->1 and
//            1->0 transitions combinationally.
// Macro    : JK_TOGGLE_SYNC_EN - when defined, q_in first passes through a
//            2-flop synchronizer (reset to 0), delaying edges by 2 cycles.
// Ports    : clk  in  - clock, rising edge
//            rst  in  - synchronous active-high reset
//            q_in in  - JK flop output (nstate)
//            rise out - q & ~q_d in the current cycle
//            fall out - ~q & q_d in the current cycle
// Revision : 1.0 - initial release
// ============================================================================
module jk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  output logic rise,
  output logic fall
);

  logic q_obs;
  logic q_d;

`ifdef JK_TOGGLE_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], q_in};
    end
  end

  assign q_obs = sync[1];
`else
  assign q_obs = q_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      q_d <= 1'b0;
    end else begin
      q_d <= q_obs;
    end
  end

  assign rise = q_obs & ~q_d;
  assign fall = ~q_obs & q_d;

endmodule : jk_edge_det
`default_nettype wire

// File: rtl/jk_toggle_meter.sv
`default_nettype none
// ============================================================================
// Module   : jk_toggle_meter
// Purpose  : Counts rising and falling transitions of the JK flop output over
//            a programmable window, then presents the counts on a valid/ready
//            result handshake.
// Macro    : JK_TOGGLE_SYNC_EN - enables the input synchronizer in jk_edge_det.
// Params   : CNT_W - transition counter width, WIN_W - window length width
// Ports    : clk, rst (sync, active-high)
//            q_in      in  - JK flop output
//            start     in  - begin measurement (IDLE only)
//            win_len   in  - window length, sampled on accepted start
//            busy      out - measurement in RUN or HOLD
//            res_valid out - result available (HOLD)
//            res_ready in  - consumer accepts result
//            rise_cnt  out - 0->1 transitions in window (saturating)
//            fall_cnt  out - 1->0 transitions in window (saturating)
//            ovf       out - a counter saturated during the window
// Revision : 1.0 - initial release
// ============================================================================
module jk_toggle_meter
  import jk_meter_pkg::*;
#(
  parameter int CNT_W = JK_CNT_W,
  parameter int WIN_W = JK_WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  jk_meter_state_t state;
  jk_meter_state_t state_next;

  logic [WIN_W-1:0] win_cnt;
  logic             rise;
  logic             fall;

  jk_edge_det u_edge_det (
    .clk  (clk),
    .rst  (rst),
    .q_in (q_in),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (win_len == '0) ? HOLD : RUN;
        end
      end
      RUN: begin
        // The cycle with win_cnt == 1 is still counted; HOLD follows it.
        if (win_cnt == WIN_ONE) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counts and ovf are cleared only on an accepted start (or reset) so that
  // the last result stays readable in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= '0;
      rise_cnt <= '0;
      fall_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            win_cnt  <= win_len;
            rise_cnt <= '0;
            fall_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        RUN: begin
          win_cnt <= win_cnt - WIN_ONE;
          if (rise) begin
            if (rise_cnt == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              rise_cnt <= rise_cnt + 1'b1;
            end
          end
          if (fall) begin
            if (fall_cnt == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              fall_cnt <= fall_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == HOLD);

endmodule : jk_toggle_meter
`default_nettype wire

// File: tb/tb_jk_toggle_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_toggle_meter
// Purpose  : Self-checking bench for jk_toggle_meter. Two instances share the
//            stimulus: the default-width DUT and a CNT_W=2 copy used for the
//            saturation case. Expected results are queued when a measurement
//            starts and popped when res_valid appears.
// Macro    : JK_TOGGLE_SYNC_EN - expected counts follow the 2-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_toggle_meter;

`ifdef JK_TOGGLE_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       q_in;
  logic       start;
  logic [7:0] win_len;
  logic       res_ready;

  logic       busy, res_valid, ovf;
  logic [7:0] rise_cnt, fall_cnt;
  logic       s_busy, s_valid, s_ovf;
  logic [1:0] s_rise, s_fall;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] r;
    logic [7:0] f;
    logic       o;
  } exp_t;

  exp_t sb_big[$];
  exp_t sb_sat[$];

  always #5 clk = ~clk;

  jk_toggle_meter u_dut (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .start     (start),
    .win_len   (win_len),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .rise_cnt  (rise_cnt),
    .fall_cnt  (fall_cnt),
    .ovf       (ovf)
  );

  jk_toggle_meter #(.CNT_W(2), .WIN_W(8)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .start     (start),
    .win_len   (win_len),
    .busy      (s_busy),
    .res_valid (s_valid),
    .res_ready (res_ready),
    .rise_cnt  (s_rise),
    .fall_cnt  (s_fall),
    .ovf       (s_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input int r, input int f, input bit o);
    exp_t e;
    e.r = r[7:0];
    e.f = f[7:0];
    e.o = o;
    return e;
  endfunction

  task automatic idle_q(input logic v, input int n);
    q_in = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  // pat[k] is q during cycle T+k, where T is the edge that accepts start.
  task automatic run_meas(input string tag, input int len, input logic [63:0] pat,
                          input exp_t eb, input bit chk_sat, input exp_t es,
                          input int bp);
    int   seen;
    exp_t e;
    exp_t e2;
    sb_big.push_back(eb);
    if (chk_sat) sb_sat.push_back(es);
    q_in    = pat[0];
    start   = 1'b1;
    win_len = len[7:0];
    tick();
    start = 1'b0;
    seen  = 0;
    for (int k = 1; k <= len + 4; k++) begin
      q_in = pat[k];
      if (res_valid) begin
        seen = k;
        break;
      end
      tick();
    end
    chk({tag, ".valid_latency"}, seen, len + 1);
    e = sb_big.pop_front();
    if (chk_sat) e2 = sb_sat.pop_front();
    if (seen == 0) return;
    chk({tag, ".rise_cnt"}, {24'd0, rise_cnt}, {24'd0, e.r});
    chk({tag, ".fall_cnt"}, {24'd0, fall_cnt}, {24'd0, e.f});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, e.o});
    if (chk_sat) begin
      chk({tag, ".sat_rise"}, {30'd0, s_rise}, {30'd0, e2.r[1:0]});
      chk({tag, ".sat_fall"}, {30'd0, s_fall}, {30'd0, e2.f[1:0]});
      chk({tag, ".sat_ovf"}, {31'd0, s_ovf}, {31'd0, e2.o});
    end
    // Back-pressure: result must stay; a start issued in HOLD must be dropped.
    for (int i = 0; i < bp; i++) begin
      start   = (i == 0);
      win_len = 8'd5;
      tick();
      chk({tag, ".held_valid"}, {31'd0, res_valid}, 32'd1);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, ".post_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, ".post_busy"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".idle_keep_rise"}, {24'd0, rise_cnt}, {24'd0, e.r});
  endtask

  initial begin
    int hits;
    rst       = 1'b1;
    q_in      = 1'b0;
    start     = 1'b0;
    win_len   = 8'd0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.valid", {31'd0, res_valid}, 32'd0);
    chk("reset.rise", {24'd0, rise_cnt}, 32'd0);
    chk("reset.fall", {24'd0, fall_cnt}, 32'd0);
    chk("reset.ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    tick();

    // Toggle window: q toggles from T+1, 8 cycles.
    idle_q(1'b0, 4);
    run_meas("toggle", 8, 64'hAAAA_AAAA_AAAA_AAAA,
             mk(SYNC ? 3 : 4, SYNC ? 3 : 4, 1'b0), 1'b0, mk(0, 0, 1'b0), 0);

    // Hold window: q stuck at 1.
    idle_q(1'b1, 4);
    run_meas("hold", 5, 64'hFFFF_FFFF_FFFF_FFFF,
             mk(0, 0, 1'b0), 1'b0, mk(0, 0, 1'b0), 0);

    // Saturation: 20-cycle window, q toggling; 2-bit copy must saturate.
    idle_q(1'b0, 4);
    run_meas("sat", 20, 64'hAAAA_AAAA_AAAA_AAAA,
             mk(SYNC ? 9 : 10, SYNC ? 9 : 10, 1'b0), 1'b1, mk(3, 3, 1'b1), 0);

    // Zero window with back-pressure and a stray start in HOLD.
    idle_q(1'b0, 2);
    run_meas("zero", 0, 64'h0, mk(0, 0, 1'b0), 1'b1, mk(0, 0, 1'b0), 5);

    // Reset in the 4th RUN cycle of a 10-cycle window.
    idle_q(1'b0, 2);
    start   = 1'b1;
    win_len = 8'd10;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      q_in = ~q_in;
      tick();
    end
    q_in = ~q_in;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_run.busy", {31'd0, busy}, 32'd0);
    chk("rst_run.valid", {31'd0, res_valid}, 32'd0);
    chk("rst_run.rise", {24'd0, rise_cnt}, 32'd0);
    chk("rst_run.fall", {24'd0, fall_cnt}, 32'd0);
    chk("rst_run.ovf", {31'd0, ovf}, 32'd0);
    hits = 0;
    for (int k = 0; k < 15; k++) begin
      q_in = ~q_in;
      tick();
      if (res_valid || busy) hits++;
    end
    chk("rst_run.no_result", hits, 32'd0);

    // Synchronizer latency: a late rise falls outside the window when synced.
    idle_q(1'b0, 4);
    run_meas("lat_late", 6, 64'hFFFF_FFFF_FFFF_FFE0,
             mk(SYNC ? 0 : 1, 0, 1'b0), 1'b0, mk(0, 0, 1'b0), 0);
    idle_q(1'b0, 4);
    run_meas("lat_early", 6, 64'hFFFF_FFFF_FFFF_FFF8,
             mk(1, 0, 1'b0), 1'b0, mk(0, 0, 1'b0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_jk_toggle_meter
`default_nettype wire
